// File: rtl/cpu_sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// cpu_sram_axi_bridge
//   Puts the fetch-side inst_sram port and the MEM-side data_sram port onto
//   one AXI3 master. Both CPU ports use the sram-like req/addr_ok/data_ok
//   protocol. At most one read and one write are outstanding at any time.
//
// Ports
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   inst_sram_*            read-only fetch port (word reads, size 2)
//   data_sram_*            load/store port (wr selects write, size 0/1/2)
//   ar*/r*                 AXI read address / read data channels
//   aw*/w*/b*              AXI write address / write data / response channels
//   dbg_r_state            current read FSM state (R_IDLE=0, R_AR=1, R_R=2)
//   dbg_w_state            current write FSM state (W_IDLE=0, W_SEND=1, W_B=2)
//
// Handshake semantics: every channel transfers in a cycle where valid and
// ready are both 1; a valid, once raised, stays high with its payload stable
// until that transfer. On the CPU side a request is taken in the cycle where
// req and addr_ok are both 1, and data_ok is a single-cycle completion pulse.
// ---------------------------------------------------------------------------
module cpu_sram_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    // inst port
    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_data_ok,
    // data port
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_data_ok,
    // read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    // state visibility
    output logic [1:0]  dbg_r_state,
    output logic [1:0]  dbg_w_state
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_B = 2'd2} w_state_t;

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;

    logic        r_owner_data;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [31:0] w_addr;
    logic [2:0]  w_size;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        aw_done, w_done;

    logic        data_rd_ok, data_wr_ok, inst_ok;
    logic        rd_accept, wr_accept;

    // Response payload fields and rid are not needed: the latched owner
    // steers read completions and only one write is ever in flight.
    logic        unused_inputs;
    assign unused_inputs = &{1'b0, rid, rresp, rlast, bid, bresp};

    function automatic logic [3:0] calc_strb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;   // size 3 behaves as a word
        endcase
    endfunction

    // Acceptance. A data read waits for the write side to be idle and a data
    // write waits while a data-owned read is in flight, so data-port
    // completions never overlap and read-after-write order is preserved.
    always_comb begin
        data_rd_ok = resetn && data_sram_req && !data_sram_wr &&
                     (r_state == R_IDLE) && (w_state == W_IDLE);
        data_wr_ok = resetn && data_sram_req && data_sram_wr && (w_state == W_IDLE) &&
                     !((r_state != R_IDLE) && r_owner_data);
        inst_ok    = resetn && inst_sram_req && (r_state == R_IDLE) &&
                     !(data_sram_req && !data_sram_wr && (w_state == W_IDLE));
        rd_accept  = data_rd_ok || inst_ok;
        wr_accept  = data_wr_ok;
    end

    // Read FSM next state and read-side outputs
    always_comb begin
        r_next            = r_state;
        arvalid           = 1'b0;
        rready            = 1'b0;
        inst_sram_data_ok = 1'b0;
        case (r_state)
            R_IDLE: if (rd_accept) r_next = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) r_next = R_R;
            end
            R_R: begin
                rready            = 1'b1;
                inst_sram_data_ok = rvalid && !r_owner_data;
                if (rvalid) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Write FSM next state and write-side outputs. awvalid and wvalid rise
    // together and each falls on its own handshake; the response phase starts
    // once both transfers are done, whatever order they arrived in.
    always_comb begin
        w_next  = w_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (w_state)
            W_IDLE: if (wr_accept) w_next = W_SEND;
            W_SEND: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) w_next = W_B;
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner_data <= 1'b0;
            r_addr       <= 32'd0;
            r_size       <= 3'd0;
            w_addr       <= 32'd0;
            w_size       <= 3'd0;
            w_data       <= 32'd0;
            w_strb       <= 4'd0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
        end else begin
            if (rd_accept) begin
                r_owner_data <= data_rd_ok;
                r_addr       <= data_rd_ok ? data_sram_addr : inst_sram_addr;
                r_size       <= data_rd_ok ? {1'b0, data_sram_size} : 3'd2;
            end
            if (wr_accept) begin
                w_addr  <= data_sram_addr;
                w_size  <= {1'b0, data_sram_size};
                w_data  <= data_sram_wdata;
                w_strb  <= calc_strb(data_sram_size, data_sram_addr[1:0]);
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (w_state == W_SEND) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end
        end
    end

    // CPU-side outputs
    assign inst_sram_addr_ok = inst_ok;
    assign data_sram_addr_ok = data_rd_ok || data_wr_ok;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;
    assign data_sram_data_ok = ((r_state == R_R) && r_owner_data && rvalid) ||
                               ((w_state == W_B) && bvalid);

    // AXI payloads
    assign arid    = r_owner_data ? ID_DATA : ID_INST;
    assign araddr  = r_addr;
    assign arsize  = r_size;
    assign awid    = ID_DATA;
    assign awaddr  = w_addr;
    assign awsize  = w_size;
    assign wid     = ID_DATA;
    assign wdata   = w_data;
    assign wstrb   = w_strb;
    assign wlast   = 1'b1;

    assign arlen   = 4'd0;
    assign awlen   = 4'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = 2'd0;
    assign awlock  = 2'd0;
    assign arcache = 4'd0;
    assign awcache = 4'd0;
    assign arprot  = 3'd0;
    assign awprot  = 3'd0;

    assign dbg_r_state = r_state;
    assign dbg_w_state = w_state;

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpu_sram_axi_bridge
//   Directed bench for cpu_sram_axi_bridge. Inputs are driven just after the
//   falling edge and outputs are checked 1 ns later, away from the rising
//   edge. Single transactions come from a vector table; arbitration, split
//   write handshakes, blocking, back-pressure and mid-read reset are
//   hand-written sequences.
// ---------------------------------------------------------------------------
module tb_cpu_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_data_ok;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [1:0]  dbg_r_state;
    logic [1:0]  dbg_w_state;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_rdata(inst_sram_rdata),
        .inst_sram_data_ok(inst_sram_data_ok),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_rdata(data_sram_rdata), .data_sram_data_ok(data_sram_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [3:0]  exp_id;
        logic [2:0]  exp_size;
        logic [3:0]  exp_strb;
    } vec_t;

    vec_t vecs[8];

    // ---------------- checker / drivers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_sram_req  = 1'b0;
        inst_sram_addr = 32'd0;
        data_sram_req  = 1'b0;
        data_sram_wr   = 1'b0;
        data_sram_size = 2'd0;
        data_sram_addr = 32'd0;
        data_sram_wdata = 32'd0;
        arready = 1'b0;
        rid     = 4'd0;
        rdata   = 32'd0;
        rresp   = 2'd0;
        rlast   = 1'b1;
        rvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bid     = 4'd0;
        bresp   = 2'd0;
        bvalid  = 1'b0;
    endtask

    // Finish a read sitting in R_AR: address beat, then one data beat.
    task automatic finish_read(input logic owner_data, input logic [31:0] rd, input string tag);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1;
        check({tag, " rready"}, {31'd0, rready}, 32'd1);
        check({tag, " arvalid_drop"}, {31'd0, arvalid}, 32'd0);
        rvalid = 1'b1;
        rdata  = rd;
        #1;
        if (owner_data) begin
            check({tag, " data_ok"}, {31'd0, data_sram_data_ok}, 32'd1);
            check({tag, " other_ok"}, {31'd0, inst_sram_data_ok}, 32'd0);
            check({tag, " rdata"}, data_sram_rdata, rd);
        end else begin
            check({tag, " data_ok"}, {31'd0, inst_sram_data_ok}, 32'd1);
            check({tag, " other_ok"}, {31'd0, data_sram_data_ok}, 32'd0);
            check({tag, " rdata"}, inst_sram_rdata, rd);
        end
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check({tag, " ok_pulse"}, {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
        check({tag, " rready_idle"}, {31'd0, rready}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        inst_sram_req   = !v.is_data;
        inst_sram_addr  = v.addr;
        data_sram_req   = v.is_data;
        data_sram_wr    = v.wr;
        data_sram_size  = v.size;
        data_sram_addr  = v.addr;
        data_sram_wdata = v.wdat;
        #1;
        check({tag, " addr_ok"}, {31'd0, v.is_data ? data_sram_addr_ok : inst_sram_addr_ok}, 32'd1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        data_sram_req = 1'b0;
        #1;
        if (!(v.is_data && v.wr)) begin
            check({tag, " arvalid"}, {31'd0, arvalid}, 32'd1);
            check({tag, " araddr"}, araddr, v.addr);
            check({tag, " arid"}, {28'd0, arid}, {28'd0, v.exp_id});
            check({tag, " arsize"}, {29'd0, arsize}, {29'd0, v.exp_size});
            finish_read(v.is_data, v.rdat, tag);
        end else begin
            check({tag, " aw_w_valid"}, {30'd0, awvalid, wvalid}, 32'd3);
            check({tag, " awaddr"}, awaddr, v.addr);
            check({tag, " awsize"}, {29'd0, awsize}, {29'd0, v.exp_size});
            check({tag, " wstrb"}, {28'd0, wstrb}, {28'd0, v.exp_strb});
            check({tag, " wdata"}, wdata, v.wdat);
            check({tag, " awid_wid"}, {24'd0, awid, wid}, 32'h11);
            awready = 1'b1;
            wready  = 1'b1;
            @(negedge clk);
            awready = 1'b0;
            wready  = 1'b0;
            #1;
            check({tag, " valids_drop"}, {30'd0, awvalid, wvalid}, 32'd0);
            check({tag, " bready"}, {31'd0, bready}, 32'd1);
            bvalid = 1'b1;
            #1;
            check({tag, " b_data_ok"}, {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd1);
            @(negedge clk);
            bvalid = 1'b0;
            #1;
            check({tag, " b_done"}, {30'd0, bready, data_sram_data_ok}, 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //            data wr  size  addr          wdata         rdata         id    size  strb
        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'hbfc00000, 32'h0,        32'h3c1d0001, 4'd0, 3'd2, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 32'h80000003, 32'h0,        32'h11223344, 4'd1, 3'd0, 4'h0};
        vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h80000102, 32'h0,        32'hcafef00d, 4'd1, 3'd1, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h80000002, 32'h00ab0000, 32'h0,        4'd1, 3'd0, 4'b0100};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 32'h80000012, 32'h56780000, 32'h0,        4'd1, 3'd1, 4'b1100};
        vecs[5] = '{1'b1, 1'b1, 2'd2, 32'h80000020, 32'hdeadbeef, 32'h0,        4'd1, 3'd2, 4'b1111};
        vecs[6] = '{1'b1, 1'b1, 2'd3, 32'h80000021, 32'h01020304, 32'h0,        4'd1, 3'd3, 4'b1111};
        vecs[7] = '{1'b1, 1'b1, 2'd0, 32'h80000031, 32'h00005a00, 32'h0,        4'd1, 3'd0, 4'b0010};

        idle_inputs();
        resetn = 1'b0;

        // Reset: requests present, nothing accepted, all handshakes low
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
        check("rst valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
        check("rst readies", {30'd0, rready, bready}, 32'd0);
        check("rst data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
        check("rst consts", {arlen, awlen, arburst, awburst, arlock, awlock, wlast, 15'd0},
              {4'd0, 4'd0, 2'b01, 2'b01, 2'd0, 2'd0, 1'b1, 15'd0});
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;

        // Single transactions from the table
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Arbitration: data read beats a simultaneous inst read
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hbfc00100;
        data_sram_req  = 1'b1;
        data_sram_wr   = 1'b0;
        data_sram_size = 2'd2;
        data_sram_addr = 32'h80001000;
        #1;
        check("arb data addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        check("arb inst addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        @(negedge clk);
        data_sram_req = 1'b0;
        #1;
        check("arb arid", {28'd0, arid}, 32'd1);
        check("arb araddr", araddr, 32'h80001000);
        check("arb inst blocked", {31'd0, inst_sram_addr_ok}, 32'd0);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h0badc0de;
        #1;
        check("arb data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd1);
        check("arb inst wait", {31'd0, inst_sram_addr_ok}, 32'd0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("arb inst addr_ok after", {31'd0, inst_sram_addr_ok}, 32'd1);
        @(negedge clk);
        inst_sram_req = 1'b0;
        #1;
        check("arb inst arid", {28'd0, arid}, 32'd0);
        check("arb inst araddr", araddr, 32'hbfc00100);
        finish_read(1'b0, 32'h24080001, "arb inst");

        // Split write handshakes: awready in cycle 1, wready in cycle 3, bvalid in cycle 5
        @(negedge clk);
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'b1;
        data_sram_size  = 2'd0;
        data_sram_addr  = 32'h80000002;
        data_sram_wdata = 32'h00ab0000;
        #1;
        check("split addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        @(negedge clk);   // cycle 1
        data_sram_req = 1'b0;
        awready = 1'b1;
        #1;
        check("split c1 valids", {30'd0, awvalid, wvalid}, 32'd3);
        @(negedge clk);   // cycle 2
        awready = 1'b0;
        #1;
        check("split c2 valids", {30'd0, awvalid, wvalid}, 32'd1);
        @(negedge clk);   // cycle 3
        wready = 1'b1;
        #1;
        check("split c3 valids", {30'd0, awvalid, wvalid}, 32'd1);
        @(negedge clk);   // cycle 4
        wready = 1'b0;
        #1;
        check("split c4 state", {29'd0, awvalid, wvalid, bready}, 32'd1);
        check("split c4 data_ok", {31'd0, data_sram_data_ok}, 32'd0);
        @(negedge clk);   // cycle 5
        bvalid = 1'b1;
        #1;
        check("split c5 data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        check("split done", {30'd0, bready, data_sram_data_ok}, 32'd0);

        // Data read blocked behind a pending write; inst read overlaps it
        @(negedge clk);
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'b1;
        data_sram_size  = 2'd2;
        data_sram_addr  = 32'h80002000;
        data_sram_wdata = 32'h12345678;
        #1;
        check("raw wr addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
        @(negedge clk);
        data_sram_wr   = 1'b0;
        data_sram_addr = 32'h80002000;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hbfc00200;
        #1;
        check("raw rd blocked send", {31'd0, data_sram_addr_ok}, 32'd0);
        check("raw inst accepted", {31'd0, inst_sram_addr_ok}, 32'd1);
        awready = 1'b1;
        wready  = 1'b1;
        @(negedge clk);
        inst_sram_req = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        #1;
        check("raw inst arid", {28'd0, arid}, 32'd0);
        check("raw rd blocked b", {31'd0, data_sram_addr_ok}, 32'd0);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h8c040000;
        #1;
        check("raw inst data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd2);
        check("raw inst rdata", inst_sram_rdata, 32'h8c040000);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("raw rd still blocked", {31'd0, data_sram_addr_ok}, 32'd0);
        bvalid = 1'b1;
        #1;
        check("raw b data_ok", {31'd0, data_sram_data_ok}, 32'd1);
        check("raw rd blocked in b", {31'd0, data_sram_addr_ok}, 32'd0);
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        check("raw rd accepted", {31'd0, data_sram_addr_ok}, 32'd1);
        @(negedge clk);
        data_sram_req = 1'b0;
        #1;
        check("raw rd arid", {28'd0, arid}, 32'd1);
        check("raw rd araddr", araddr, 32'h80002000);
        finish_read(1'b1, 32'h12345678, "raw rd");

        // arready back-pressure: payload stable, no new acceptances
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hbfc00300;
        #1;
        check("bp accept", {31'd0, inst_sram_addr_ok}, 32'd1);
        @(negedge clk);
        inst_sram_addr = 32'hbfc00400;
        data_sram_req  = 1'b1;
        data_sram_wr   = 1'b0;
        data_sram_addr = 32'h80003000;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp c%0d ar", c), {arvalid, arid, arsize, 24'd0},
                  {1'b1, 4'd0, 3'd2, 24'd0});
            check($sformatf("bp c%0d araddr", c), araddr, 32'hbfc00300);
            check($sformatf("bp c%0d addr_ok", c),
                  {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
            @(negedge clk);
        end
        inst_sram_req = 1'b0;
        data_sram_req = 1'b0;
        finish_read(1'b0, 32'h00000000, "bp");

        // Reset while the read is in R_R; stale rvalid afterwards is ignored
        @(negedge clk);
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hbfc00500;
        @(negedge clk);
        inst_sram_req = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1;
        check("mrst in R_R", {31'd0, rready}, 32'd1);
        resetn = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hffffffff;
        inst_sram_req = 1'b1;
        #1;
        check("mrst handshakes", {30'd0, arvalid, rready}, 32'd0);
        check("mrst data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
        check("mrst addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        @(negedge clk);
        inst_sram_req = 1'b0;
        resetn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("mrst stray c%0d", c),
                  {29'd0, rready, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
            @(negedge clk);
        end
        rvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
